odd_rf_fwd: RTL and testbench

- Operand-fetch end of the odd-pipe result path. Consumes the odd pipe's per-stage result taps (stages 2-7) and retires the stage-7 result into a 128 x 128-bit register file.
- Supplies up to three source operands (RA, RB, RC) to the next odd-pipe issue, with full bypass from in-flight stages.
- Output is registered: one-cycle operand-fetch stage between decode/issue and the odd pipe inputs.

---
 rtl/odd_rf_fwd_pkg.sv | 19 +
 rtl/odd_fwd_sel.sv | 22 ++
 rtl/odd_rf_fwd.sv | 105 ++++++++++
 tb/tb_odd_rf_fwd.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/odd_rf_fwd_pkg.sv
// Shared widths, forwarding-window bounds and the stage tap record
// for the odd-pipe operand-fetch block.
package odd_rf_fwd_pkg;

  localparam int REG_ADDR_WD   = 7;
  localparam int REG_DATA_WD   = 128;
  localparam int NUM_REGS      = 128;
  localparam int ODD_FWD_FIRST = 2;
  localparam int ODD_FWD_LAST  = 7;
  localparam int NUM_TAPS      = ODD_FWD_LAST - ODD_FWD_FIRST + 1;

  // One in-flight result as seen from the operand-fetch stage
  typedef struct packed {
    logic                   vld;
    logic [REG_ADDR_WD-1:0] addr;
    logic [REG_DATA_WD-1:0] data;
  } fwd_tap_t;

endpackage

// File: rtl/odd_fwd_sel.sv
// Single-operand bypass selector: picks the youngest valid stage result
// whose destination matches the source address, else the register file word.
module odd_fwd_sel
  import odd_rf_fwd_pkg::*;
(
  input  fwd_tap_t [NUM_TAPS-1:0]   taps,
  input  logic [REG_ADDR_WD-1:0]    addr,
  input  logic [REG_DATA_WD-1:0]    rf_data,
  output logic [REG_DATA_WD-1:0]    data
);

  // Walk oldest to youngest so the youngest match (tap 0 = stage 2) wins
  always_comb begin
    data = rf_data;
    for (int i = NUM_TAPS - 1; i >= 0; i--) begin
      if (taps[i].vld && (taps[i].addr == addr)) begin
        data = taps[i].data;
      end
    end
  end

endmodule

// File: rtl/odd_rf_fwd.sv
// Odd-pipe register file with stage-7 writeback and a registered
// three-operand fetch stage that bypasses from stages 2 through 7.
module odd_rf_fwd
  import odd_rf_fwd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic [REG_ADDR_WD-1:0]  rd_addr_ra,
  input  logic [REG_ADDR_WD-1:0]  rd_addr_rb,
  input  logic [REG_ADDR_WD-1:0]  rd_addr_rc,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    vld_s2,
  input  logic                    vld_s3,
  input  logic                    vld_s4,
  input  logic                    vld_s5,
  input  logic                    vld_s6,
  input  logic                    vld_s7,
  input  logic [REG_ADDR_WD-1:0]  rf_addr_s2_op,
  input  logic [REG_ADDR_WD-1:0]  rf_addr_s3_op,
  input  logic [REG_ADDR_WD-1:0]  rf_addr_s4_op,
  input  logic [REG_ADDR_WD-1:0]  rf_addr_s5_op,
  input  logic [REG_ADDR_WD-1:0]  rf_addr_s6_op,
  input  logic [REG_ADDR_WD-1:0]  rf_addr_s7_op,
  input  logic [REG_DATA_WD-1:0]  rf_data_s2_op,
  input  logic [REG_DATA_WD-1:0]  rf_data_s3_op,
  input  logic [REG_DATA_WD-1:0]  rf_data_s4_op,
  input  logic [REG_DATA_WD-1:0]  rf_data_s5_op,
  input  logic [REG_DATA_WD-1:0]  rf_data_s6_op,
  input  logic [REG_DATA_WD-1:0]  rf_data_s7_op,
  output logic                    op_vld,
  output logic [REG_DATA_WD-1:0]  out_RA,
  output logic [REG_DATA_WD-1:0]  out_RB,
  output logic [REG_DATA_WD-1:0]  out_RC
);

  logic [REG_DATA_WD-1:0]  rf [NUM_REGS];
  fwd_tap_t [NUM_TAPS-1:0] taps;
  logic [REG_DATA_WD-1:0]  sel_ra;
  logic [REG_DATA_WD-1:0]  sel_rb;
  logic [REG_DATA_WD-1:0]  sel_rc;

  // Tap 0 is the youngest stage (s2), tap 5 the oldest (s7)
  assign taps[0] = {vld_s2, rf_addr_s2_op, rf_data_s2_op};
  assign taps[1] = {vld_s3, rf_addr_s3_op, rf_data_s3_op};
  assign taps[2] = {vld_s4, rf_addr_s4_op, rf_data_s4_op};
  assign taps[3] = {vld_s5, rf_addr_s5_op, rf_data_s5_op};
  assign taps[4] = {vld_s6, rf_addr_s6_op, rf_data_s6_op};
  assign taps[5] = {vld_s7, rf_addr_s7_op, rf_data_s7_op};

  // Register file: reset clears every entry, otherwise stage 7 retires one write
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (vld_s7) begin
      rf[rf_addr_s7_op] <= rf_data_s7_op;
    end
  end

  odd_fwd_sel u_sel_ra (
    .taps    (taps),
    .addr    (rd_addr_ra),
    .rf_data (rf[rd_addr_ra]),
    .data    (sel_ra)
  );

  odd_fwd_sel u_sel_rb (
    .taps    (taps),
    .addr    (rd_addr_rb),
    .rf_data (rf[rd_addr_rb]),
    .data    (sel_rb)
  );

  odd_fwd_sel u_sel_rc (
    .taps    (taps),
    .addr    (rd_addr_rc),
    .rf_data (rf[rd_addr_rc]),
    .data    (sel_rc)
  );

  // Operand-fetch output stage: flush drops validity, stall freezes everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_vld <= 1'b0;
      out_RA <= '0;
      out_RB <= '0;
      out_RC <= '0;
    end else if (flush) begin
      op_vld <= 1'b0;
    end else if (stall) begin
      op_vld <= op_vld;
    end else if (rd_en) begin
      op_vld <= 1'b1;
      out_RA <= sel_ra;
      out_RB <= sel_rb;
      out_RC <= sel_rc;
    end else begin
      op_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_odd_rf_fwd.sv
// Self-checking bench for odd_rf_fwd: directed scenarios followed by
// randomized traffic, all checked against a behavioural register-file model.
module tb_odd_rf_fwd;

  logic         clk;
  logic         rst;
  logic         rd_en;
  logic [6:0]   ra;
  logic [6:0]   rb;
  logic [6:0]   rc;
  logic         stall;
  logic         flush;
  logic         vld [2:7];
  logic [6:0]   ta  [2:7];
  logic [127:0] td  [2:7];
  logic         op_vld;
  logic [127:0] out_RA;
  logic [127:0] out_RB;
  logic [127:0] out_RC;

  // Reference state: architectural register file and expected output registers
  logic [127:0] m_rf [128];
  logic         exp_vld;
  logic [127:0] exp_ra;
  logic [127:0] exp_rb;
  logic [127:0] exp_rc;

  int total;
  int bad;

  odd_rf_fwd dut (
    .clk           (clk),
    .rst           (rst),
    .rd_en         (rd_en),
    .rd_addr_ra    (ra),
    .rd_addr_rb    (rb),
    .rd_addr_rc    (rc),
    .stall         (stall),
    .flush         (flush),
    .vld_s2        (vld[2]),
    .vld_s3        (vld[3]),
    .vld_s4        (vld[4]),
    .vld_s5        (vld[5]),
    .vld_s6        (vld[6]),
    .vld_s7        (vld[7]),
    .rf_addr_s2_op (ta[2]),
    .rf_addr_s3_op (ta[3]),
    .rf_addr_s4_op (ta[4]),
    .rf_addr_s5_op (ta[5]),
    .rf_addr_s6_op (ta[6]),
    .rf_addr_s7_op (ta[7]),
    .rf_data_s2_op (td[2]),
    .rf_data_s3_op (td[3]),
    .rf_data_s4_op (td[4]),
    .rf_data_s5_op (td[5]),
    .rf_data_s6_op (td[6]),
    .rf_data_s7_op (td[7]),
    .op_vld        (op_vld),
    .out_RA        (out_RA),
    .out_RB        (out_RB),
    .out_RC        (out_RC)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Value an issue to address a would see: youngest valid in-flight result, else the file
  function automatic logic [127:0] resolve(input logic [6:0] a);
    for (int s = 2; s <= 7; s++) begin
      if (vld[s] && ta[s] == a) return td[s];
    end
    return m_rf[a];
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic clearInputs();
    rst   = 1'b1;
    rd_en = 1'b0;
    ra    = '0;
    rb    = '0;
    rc    = '0;
    stall = 1'b0;
    flush = 1'b0;
    for (int s = 2; s <= 7; s++) begin
      vld[s] = 1'b0;
      ta[s]  = '0;
      td[s]  = '0;
    end
  endtask

  // Advance one clock with the current inputs, update the model, compare all outputs
  task automatic applyStimulus(input string tag);
    if (!rst) begin
      exp_vld = 1'b0;
      exp_ra  = '0;
      exp_rb  = '0;
      exp_rc  = '0;
      for (int i = 0; i < 128; i++) m_rf[i] = '0;
    end else begin
      if (flush) begin
        exp_vld = 1'b0;
      end else if (stall) begin
        exp_vld = exp_vld;
      end else if (rd_en) begin
        exp_vld = 1'b1;
        exp_ra  = resolve(ra);
        exp_rb  = resolve(rb);
        exp_rc  = resolve(rc);
      end else begin
        exp_vld = 1'b0;
      end
      if (vld[7]) m_rf[ta[7]] = td[7];
    end
    @(posedge clk);
    #1;
    checkOutput({tag, ".op_vld"}, {127'd0, op_vld}, {127'd0, exp_vld});
    checkOutput({tag, ".RA"}, out_RA, exp_ra);
    checkOutput({tag, ".RB"}, out_RB, exp_rb);
    checkOutput({tag, ".RC"}, out_RC, exp_rc);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_vld = 1'b0;
    exp_ra  = '0;
    exp_rb  = '0;
    exp_rc  = '0;
    for (int i = 0; i < 128; i++) m_rf[i] = '0;
    clearInputs();
    @(negedge clk);

    // Reset, then read untouched registers
    rst = 1'b0;
    applyStimulus("reset");
    clearInputs();
    rd_en = 1'b1; ra = 7'd5; rb = 7'd6; rc = 7'd7;
    applyStimulus("read_after_reset");
    checkOutput("read_after_reset.RA_zero", out_RA, 128'd0);

    // Writeback then read
    clearInputs();
    vld[7] = 1'b1; ta[7] = 7'd10; td[7] = {16{8'hA5}};
    applyStimulus("wb10");
    clearInputs();
    rd_en = 1'b1; ra = 7'd10;
    applyStimulus("read10");
    checkOutput("read10.A5", out_RA, {16{8'hA5}});

    // Bypass priority s2 > s5 > file
    clearInputs();
    vld[7] = 1'b1; ta[7] = 7'd3; td[7] = 128'h11;
    applyStimulus("wb3");
    clearInputs();
    rd_en = 1'b1; ra = 7'd3;
    vld[2] = 1'b1; ta[2] = 7'd3; td[2] = 128'h22;
    vld[5] = 1'b1; ta[5] = 7'd3; td[5] = 128'h55;
    applyStimulus("byp_s2");
    checkOutput("byp_s2.const", out_RA, 128'h22);
    vld[2] = 1'b0;
    applyStimulus("byp_s5");
    checkOutput("byp_s5.const", out_RA, 128'h55);
    vld[5] = 1'b0;
    applyStimulus("byp_rf");
    checkOutput("byp_rf.const", out_RA, 128'h11);

    // Invalid tap with matching address must not forward
    vld[4] = 1'b0; ta[4] = 7'd3; td[4] = 128'hDEAD;
    applyStimulus("byp_invalid");

    // Same-cycle write and read of address 20
    clearInputs();
    vld[7] = 1'b1; ta[7] = 7'd20; td[7] = 128'h77;
    rd_en = 1'b1; ra = 7'd20; rb = 7'd20; rc = 7'd20;
    applyStimulus("wr_rd_same");
    checkOutput("wr_rd_same.RC_const", out_RC, 128'h77);
    clearInputs();
    rd_en = 1'b1; ra = 7'd20;
    applyStimulus("rf20");
    checkOutput("rf20.const", out_RA, 128'h77);

    // Stall holds, flush under stall drops validity
    clearInputs();
    vld[7] = 1'b1; ta[7] = 7'd4; td[7] = 128'h9;
    applyStimulus("wb4");
    clearInputs();
    rd_en = 1'b1; ra = 7'd4;
    applyStimulus("read4");
    rd_en = 1'b1; ra = 7'd20; stall = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus("stall");
    checkOutput("stall.hold9", out_RA, 128'h9);
    checkOutput("stall.vld_held", {127'd0, op_vld}, 128'd1);
    flush = 1'b1;
    applyStimulus("flush_stall");
    checkOutput("flush_stall.vld0", {127'd0, op_vld}, 128'd0);

    // Reset in the same cycle as a write and a read: write is lost
    clearInputs();
    rst = 1'b0;
    vld[7] = 1'b1; ta[7] = 7'd1; td[7] = rand128();
    rd_en = 1'b1; ra = 7'd1;
    applyStimulus("rst_mid");
    clearInputs();
    rd_en = 1'b1; ra = 7'd1; rb = 7'd20; rc = 7'd4;
    applyStimulus("rst_mid_read");
    checkOutput("rst_mid_read.rf1_zero", out_RA, 128'd0);

    // Randomized traffic concentrated on a few addresses to provoke collisions
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 59) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rd_en = ($urandom_range(0, 3) != 0);
      ra    = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      rb    = 7'($urandom_range(0, 7));
      rc    = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      for (int s = 2; s <= 7; s++) begin
        vld[s] = $urandom_range(0, 1) == 1;
        ta[s]  = 7'($urandom_range(0, 7));
        td[s]  = rand128();
      end
      applyStimulus("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
